// File: rtl/uart_pkg.sv
// Shared UART definitions.
// Used by the TX engine and the future RX engine.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int STOP_ONE = 1;
  localparam int STOP_TWO = 2;

endpackage

// File: rtl/uart_baud_gen.sv
// Divide-by-CLKS_PER_BIT bit timer.
// bit_end is high on the final count of each bit period.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic bit_end
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;

  assign bit_end = en && (cnt_q == LAST);

  // count 0..CLKS_PER_BIT-1 while enabled, wrap on the final count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= bit_end ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit engine fed from the byte FIFO read port.
// Pops one word per frame and serialises it LSB-first.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic                  fifo_rd_valid,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] LAST_STOP =
    (STOP_BITS == STOP_TWO) ? BW'(1) : BW'(0);
  localparam logic ODD_BIT = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

  tx_state_e state_q, state_d;

  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic                  par_q, par_d;
  logic                  tx_q, tx_d;
  logic                  done_q, done_d;
  logic                  baud_en, baud_clr, bit_end;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .clr    (baud_clr),
    .en     (baud_en),
    .bit_end(bit_end)
  );

  assign fifo_rd_en = (state_q == IDLE) && !fifo_empty;
  assign busy       = (state_q != IDLE);
  assign tx         = tx_q;
  assign tx_done    = done_q;

  // next state, datapath updates and the next line level
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bit_d    = bit_q;
    par_d    = par_q;
    done_d   = 1'b0;
    baud_en  = 1'b0;
    baud_clr = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) state_d = FETCH;
      end
      FETCH: begin
        if (fifo_rd_valid) begin
          shift_d  = fifo_data;
          par_d    = ^fifo_data ^ ODD_BIT;
          bit_d    = '0;
          baud_clr = 1'b1;
          state_d  = START;
        end
      end
      START: begin
        baud_en = 1'b1;
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        baud_en = 1'b1;
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == LAST_DATA) begin
            bit_d   = '0;
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      PARITY: begin
        baud_en = 1'b1;
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        baud_en = 1'b1;
        if (bit_end) begin
          if (bit_q == LAST_STOP) begin
            bit_d   = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
  end

  // state, datapath and registered line output
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine.
// Four parameter sets, each fed by a small FIFO model.
module tb_uart_tx_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] f_empty;
  logic [3:0] f_rd_en;
  logic [3:0] f_valid = '0;
  logic [3:0] tx;
  logic [3:0] busy;
  logic [3:0] done;
  logic [7:0] f_data [4];
  logic [7:0] mem [4][8];
  int         wp [4] = '{0, 0, 0, 0};
  int         rp [4] = '{0, 0, 0, 0};
  int         pops [4] = '{0, 0, 0, 0};
  logic       inj_v;
  logic [7:0] inj_d;
  logic       cap_tx [128];
  logic       cap_busy [128];
  logic       cap_done [128];
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  uart_tx_engine #(
    .DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0),
    .PARITY_ODD(0), .STOP_BITS(1)
  ) u0 (
    .clk(clk), .rst(rst), .fifo_empty(f_empty[0]),
    .fifo_rd_en(f_rd_en[0]),
    .fifo_rd_valid(f_valid[0] | inj_v),
    .fifo_data(inj_v ? inj_d : f_data[0]),
    .tx(tx[0]), .busy(busy[0]), .tx_done(done[0])
  );

  uart_tx_engine #(
    .DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1),
    .PARITY_ODD(0), .STOP_BITS(1)
  ) u1 (
    .clk(clk), .rst(rst), .fifo_empty(f_empty[1]),
    .fifo_rd_en(f_rd_en[1]), .fifo_rd_valid(f_valid[1]),
    .fifo_data(f_data[1]),
    .tx(tx[1]), .busy(busy[1]), .tx_done(done[1])
  );

  uart_tx_engine #(
    .DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1),
    .PARITY_ODD(1), .STOP_BITS(1)
  ) u2 (
    .clk(clk), .rst(rst), .fifo_empty(f_empty[2]),
    .fifo_rd_en(f_rd_en[2]), .fifo_rd_valid(f_valid[2]),
    .fifo_data(f_data[2]),
    .tx(tx[2]), .busy(busy[2]), .tx_done(done[2])
  );

  uart_tx_engine #(
    .DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0),
    .PARITY_ODD(0), .STOP_BITS(2)
  ) u3 (
    .clk(clk), .rst(rst), .fifo_empty(f_empty[3]),
    .fifo_rd_en(f_rd_en[3]), .fifo_rd_valid(f_valid[3]),
    .fifo_data(f_data[3]),
    .tx(tx[3]), .busy(busy[3]), .tx_done(done[3])
  );

  // FIFO empty flags
  always_comb begin
    for (int i = 0; i < 4; i++) f_empty[i] = (wp[i] == rp[i]);
  end

  // FIFO read port: registered data, valid one cycle after the pop
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      f_valid[i] <= 1'b0;
      if (f_rd_en[i] && !f_empty[i]) begin
        f_data[i]  <= mem[i][rp[i] % 8];
        f_valid[i] <= 1'b1;
        rp[i]      <= rp[i] + 1;
      end
    end
  end

  // pop counter per instance, sampled mid-cycle
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++)
      if (f_rd_en[i]) pops[i] <= pops[i] + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic push(input int i, input logic [7:0] d);
    mem[i][wp[i] % 8] = d;
    wp[i] = wp[i] + 1;
  endtask

  task automatic capture(input int i, input int n, input bit inj);
    int w;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (tx[i] && w < 500);
    chk("fall", 32'(tx[i]), 0);
    for (int c = 0; c < n; c++) begin
      if (c > 0) @(negedge clk);
      cap_tx[c]   = tx[i];
      cap_busy[c] = busy[i];
      cap_done[c] = done[i];
      if (inj) inj_v = (c == 0);
    end
  endtask

  function automatic logic [31:0] frame(input int off, input int nb);
    logic [31:0] v;
    v = '0;
    for (int k = 0; k < nb; k++) v[k] = cap_tx[off + 4 * k + 1];
    return v;
  endfunction

  function automatic int first_done(input int from, input int n);
    for (int c = from; c < n; c++) if (cap_done[c]) return c;
    return -1;
  endfunction

  initial begin
    int p;
    int w;
    int cnt;
    logic [9:0] pat;
    bit s_tx, s_busy, s_rd;

    inj_v = 1'b0;
    inj_d = 8'h55;
    rst   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx), 32'hF);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_rd_en", 32'(f_rd_en), 0);
    rst = 1'b1;

    s_tx = 0; s_busy = 0; s_rd = 0;
    repeat (1000) begin
      @(negedge clk);
      if (tx != 4'hF) s_tx = 1;
      if (busy != 4'h0) s_busy = 1;
      if (f_rd_en != 4'h0) s_rd = 1;
    end
    chk("idle_tx_low", 32'(s_tx), 0);
    chk("idle_busy", 32'(s_busy), 0);
    chk("idle_rd_en", 32'(s_rd), 0);

    p = pops[0];
    @(posedge clk); #1;
    push(0, 8'hA5);
    w = 0;
    do begin
      @(posedge clk); #1;
      w++;
    end while (tx[0] && w < 20);
    chk("late_start", w, 2);
    capture(0, 48, 0);
    pat = {1'b1, 8'hA5, 1'b0};
    for (int k = 0; k < 10; k++)
      chk("a5_bit", 32'(cap_tx[4 * k + 1]), 32'(pat[k]));
    chk("a5_done", first_done(0, 48), 40);
    chk("a5_busy_mid", 32'(cap_busy[20]), 1);
    chk("a5_busy_end", 32'(cap_busy[40]), 0);
    chk("a5_pops", pops[0] - p, 1);

    @(posedge clk); #1;
    push(1, 8'hA5);
    capture(1, 52, 0);
    chk("pe_a5_frame", frame(0, 11), 32'({2'b10, 8'hA5, 1'b0}));
    chk("pe_a5_par", 32'(cap_tx[37]), 0);
    chk("pe_a5_done", first_done(0, 52), 44);

    @(posedge clk); #1;
    push(1, 8'h07);
    capture(1, 52, 0);
    chk("pe_07_frame", frame(0, 11), 32'({2'b11, 8'h07, 1'b0}));
    chk("pe_07_par", 32'(cap_tx[37]), 1);
    chk("pe_07_done", first_done(0, 52), 44);

    @(posedge clk); #1;
    push(2, 8'hA5);
    capture(2, 52, 0);
    chk("po_a5_frame", frame(0, 11), 32'({2'b11, 8'hA5, 1'b0}));
    chk("po_a5_par", 32'(cap_tx[37]), 1);

    p = pops[3];
    @(posedge clk); #1;
    push(3, 8'h00);
    push(3, 8'hFF);
    capture(3, 96, 0);
    chk("b2b_frame1", frame(0, 11), 32'({2'b11, 8'h00, 1'b0}));
    chk("b2b_data_end", 32'(cap_tx[35]), 0);
    cnt = 0;
    for (int c = 36; c < 46; c++) if (cap_tx[c]) cnt++;
    chk("b2b_high_run", cnt, 10);
    chk("b2b_start2", 32'(cap_tx[46]), 0);
    chk("b2b_frame2", frame(46, 11), 32'({2'b11, 8'hFF, 1'b0}));
    cnt = 0;
    for (int c = 0; c < 90; c++) if (!cap_busy[c]) cnt++;
    chk("b2b_idle_cnt", cnt, 1);
    chk("b2b_idle_at", 32'(cap_busy[44]), 0);
    chk("b2b_done1", first_done(0, 96), 44);
    chk("b2b_done2", first_done(45, 96), 90);
    chk("b2b_pops", pops[3] - p, 2);

    p = pops[0];
    @(posedge clk); #1;
    push(0, 8'hA5);
    capture(0, 48, 1);
    inj_v = 1'b0;
    chk("spur_frame", frame(0, 10), 32'({1'b1, 8'hA5, 1'b0}));
    chk("spur_done", first_done(0, 48), 40);
    chk("spur_pops", pops[0] - p, 1);

    p = pops[0];
    @(posedge clk); #1;
    push(0, 8'h3C);
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (tx[0] && w < 50);
    chk("rst_fall", 32'(tx[0]), 0);
    repeat (17) @(negedge clk);
    chk("rst_pre_busy", 32'(busy[0]), 1);
    rst = 1'b0;
    #1;
    chk("rst_async_tx", 32'(tx[0]), 1);
    chk("rst_async_busy", 32'(busy[0]), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    s_tx = 0; s_busy = 0;
    repeat (200) begin
      @(negedge clk);
      if (!tx[0]) s_tx = 1;
      if (busy[0]) s_busy = 1;
    end
    chk("post_rst_tx", 32'(s_tx), 0);
    chk("post_rst_busy", 32'(s_busy), 0);
    chk("post_rst_pops", pops[0] - p, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
